// File: rtl/button_event_arbiter.sv
// Synchronizes, debounces and edge-detects NUM_BTN push-buttons, then serializes
// captured presses round-robin onto one valid/ready event channel.
module button_event_arbiter #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int ID_W            = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic [NUM_BTN-1:0] pending,
    output logic [NUM_BTN-1:0] overrun,
    input  logic               ovr_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync_p0;
    logic [NUM_BTN-1:0] sync_p1;
    logic [NUM_BTN-1:0] db;
    logic [CNT_W-1:0]   cnt [NUM_BTN];
    logic [NUM_BTN-1:0] flip;
    logic [NUM_BTN-1:0] rise;

    logic               free;
    logic               found;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    ptr;
    logic [NUM_BTN-1:0] grant;
    int                 idx;

    always_comb begin
        flip = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            flip[i] = (sync_p1[i] != db[i]) && (cnt[i] == CNT_LAST);
        end
        rise = flip & ~db;
    end

    // Synchronizer and debounce stage
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db      <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            db      <= db ^ flip;
            for (int i = 0; i < NUM_BTN; i++) begin
                if ((sync_p1[i] == db[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Round-robin search starting at ptr, wrapping past the top index
    always_comb begin
        free  = !evt_valid || evt_ready;
        found = 1'b0;
        sel   = '0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_BTN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_BTN) begin
                idx = idx - NUM_BTN;
            end
            if (!found && pending[ID_W'(idx)]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
        if (free && found) begin
            grant[sel] = 1'b1;
        end
    end

    // Pending/overrun capture and output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            ptr       <= '0;
            pending   <= '0;
            overrun   <= '0;
        end else begin
            if (free) begin
                if (found) begin
                    evt_valid <= 1'b1;
                    evt_id    <= sel;
                    if (int'(sel) == NUM_BTN - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= sel + 1'b1;
                    end
                end else begin
                    evt_valid <= 1'b0;
                end
            end
            // A press landing on a bit being granted this cycle is kept, not an overrun
            pending <= (pending & ~grant) | rise;
            overrun <= (ovr_clr ? '0 : overrun) | (rise & pending & ~grant);
        end
    end

endmodule
